// File: rtl/im_loader.sv
// Instruction-memory loader: receives a length-prefixed byte
// stream, writes 32-bit words and verifies an XOR checksum.
module im_loader #(
    parameter int IMEM_SIZE = 256
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic        WE,
    output logic [31:0] W_Addr,
    output logic [31:0] W_Ins,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_CSUM
    } state_t;

    localparam logic [16:0] LP_MAX = 17'(IMEM_SIZE);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic [23:0] r_asm;
    logic [31:0] r_addr;
    logic [31:0] r_ins;
    logic [7:0]  r_csum;
    logic        r_done;
    logic        r_err;
    logic        w_acc;
    logic [15:0] w_len;
    logic        w_len_bad;

    assign RX_READY = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                      (r_state == S_DATA) || (r_state == S_CSUM);
    assign WE       = (r_state == S_WRITE);
    assign BUSY     = (r_state != S_IDLE);
    assign W_Addr   = r_addr;
    assign W_Ins    = r_ins;
    assign DONE     = r_done;
    assign ERR      = r_err;

    assign w_acc     = RX_VALID && RX_READY;
    assign w_len     = {RX_DATA, r_cnt[7:0]};
    assign w_len_bad = (w_len == 16'd0) || ({1'b0, w_len} > LP_MAX);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (START) w_next = S_LEN0;
            S_LEN0:  if (w_acc) w_next = S_LEN1;
            S_LEN1:  if (w_acc) w_next = w_len_bad ? S_IDLE : S_DATA;
            S_DATA:  if (w_acc && (r_idx == 2'd3)) w_next = S_WRITE;
            S_WRITE: w_next = (r_cnt == 16'd1) ? S_CSUM : S_DATA;
            S_CSUM:  if (w_acc) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: length, word assembly, address, checksum, result flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_asm  <= '0;
            r_addr <= '0;
            r_ins  <= '0;
            r_csum <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_cnt  <= '0;
                        r_idx  <= '0;
                        r_addr <= '0;
                        r_csum <= '0;
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
                S_LEN0: begin
                    if (w_acc) r_cnt <= {8'd0, RX_DATA};
                end
                S_LEN1: begin
                    if (w_acc) begin
                        if (w_len_bad) r_err <= 1'b1;
                        else           r_cnt <= w_len;
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_csum <= r_csum ^ RX_DATA;
                        r_idx  <= r_idx + 2'd1;
                        // W_Ins only moves when the full word is ready
                        if (r_idx == 2'd3) r_ins <= {RX_DATA, r_asm};
                        else               r_asm <= {RX_DATA, r_asm[23:8]};
                    end
                end
                S_WRITE: begin
                    r_addr <= r_addr + 32'd4;
                    r_cnt  <= r_cnt - 16'd1;
                end
                S_CSUM: begin
                    if (w_acc) begin
                        r_done <= (RX_DATA == r_csum);
                        r_err  <= (RX_DATA != r_csum);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
